// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the mini-MIPS datapath.
// master: controller side (takes IR fields + mem_ready, drives all enables/selects/debug).
// slave:  datapath side (drives IR fields + mem_ready, takes the controls).
interface multicycle_controller_if;
  // IR fields and memory handshake, sourced by the datapath
  logic [5:0]  opcode;
  logic [5:0]  fn;
  logic        mem_ready;

  // datapath enables and selects, sourced by the controller
  logic        irwrite;
  logic        pcwrite;
  logic        pcwritecond;
  logic        iord;
  logic        rd;
  logic        we;
  logic        regwrite;
  logic        alusrc;
  logic [1:0]  regdst;
  logic [1:0]  reginsrc;
  logic [1:0]  brtype;
  logic [1:0]  pcsrc;
  logic        illegal;

  // debug / statistics
  logic [3:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  opcode, fn, mem_ready,
    output irwrite, pcwrite, pcwritecond, iord, rd, we, regwrite, alusrc,
           regdst, reginsrc, brtype, pcsrc, illegal, state, instr_count
  );

  modport slave (
    output opcode, fn, mem_ready,
    input  irwrite, pcwrite, pcwritecond, iord, rd, we, regwrite, alusrc,
           regdst, reginsrc, brtype, pcsrc, illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style multicycle control FSM for the mini-MIPS datapath with one shared memory port.
// Latency: FETCH->FETCH 4 (R/I-ALU, sw), 5 (lw), 3 (branch/j/jr/syscall), 2 (illegal) plus mem stalls.
// Backpressure: FETCH, MEMRD and MEMWR hold with rd/we/iord steady until mem_ready is seen.
// Ports: clk, rst (async active-high); bus = multicycle_controller_if.master carrying
// opcode/fn/mem_ready in and the datapath enables, selects, illegal pulse, state and instr_count out.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    ALUWB_R = 4'd4,
    ALUWB_I = 4'd5,
    MEMADDR = 4'd6,
    MEMRD   = 4'd7,
    MEMWB   = 4'd8,
    MEMWR   = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11,
    JR      = 4'd12,
    SYSCALL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_BEQ   = 6'b000010;
  localparam logic [5:0] OP_J     = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  state_t      state_q;
  state_t      state_d;
  state_t      decode_target;
  logic        decode_bad;
  logic        retire;
  logic [31:0] instr_count_q;

  // Instruction class lookup; FETCH doubles as the "undecodable" marker since
  // DECODE never legitimately returns straight to FETCH.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] f);
    state_t nxt;
    nxt = FETCH;
    case (op)
      OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = EXEC_I;
      OP_LW, OP_SW:                              nxt = MEMADDR;
      OP_BLTZ, OP_BEQ, OP_BNE:                   nxt = BRANCH;
      OP_J:                                      nxt = JUMP;
      OP_RTYPE: begin
        case (f)
          FN_ADD, FN_SUB: nxt = EXEC_R;
          FN_JR:          nxt = JR;
          FN_SYSCALL:     nxt = SYSCALL;
          default:        nxt = FETCH;
        endcase
      end
      default: nxt = FETCH;
    endcase
    return nxt;
  endfunction

  always_comb begin
    decode_target = decode_next(bus.opcode, bus.fn);
    decode_bad    = (decode_target == FETCH);
  end

  // State register: reset lands in FETCH immediately, aborting any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. mem_ready only matters in the three memory-access states.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE:  state_d = decode_target;
      EXEC_R:  state_d = ALUWB_R;
      EXEC_I:  state_d = ALUWB_I;
      ALUWB_R: state_d = FETCH;
      ALUWB_I: state_d = FETCH;
      MEMADDR: state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      JR:      state_d = FETCH;
      SYSCALL: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output logic. Everything is a function of state except the FETCH
  // irwrite/pcwrite (same-cycle mem_ready), the DECODE illegal pulse and the
  // BRANCH brtype select. Held at zero during reset even though state reads FETCH.
  always_comb begin
    bus.irwrite     = 1'b0;
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.rd          = 1'b0;
    bus.we          = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrc      = 1'b0;
    bus.regdst      = 2'b00;
    bus.reginsrc    = 2'b00;
    bus.brtype      = 2'b00;
    bus.pcsrc       = 2'b00;
    bus.illegal     = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.rd      = 1'b1;
          bus.irwrite = bus.mem_ready;
          bus.pcwrite = bus.mem_ready;
        end
        DECODE: begin
          bus.illegal = decode_bad;
        end
        EXEC_R: begin
          bus.alusrc = 1'b0;
        end
        EXEC_I: begin
          bus.alusrc = 1'b1;
        end
        ALUWB_R: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 2'b01;
          bus.reginsrc = 2'b01;
        end
        ALUWB_I: begin
          bus.regwrite = 1'b1;
          bus.reginsrc = 2'b01;
          bus.alusrc   = 1'b1;
        end
        MEMADDR: begin
          bus.alusrc = 1'b1;
        end
        MEMRD: begin
          bus.rd     = 1'b1;
          bus.iord   = 1'b1;
          bus.alusrc = 1'b1;
        end
        MEMWB: begin
          bus.regwrite = 1'b1;
        end
        MEMWR: begin
          bus.we     = 1'b1;
          bus.iord   = 1'b1;
          bus.alusrc = 1'b1;
        end
        BRANCH: begin
          bus.pcwritecond = 1'b1;
          case (bus.opcode)
            OP_BLTZ: bus.brtype = 2'b11;
            OP_BEQ:  bus.brtype = 2'b01;
            OP_BNE:  bus.brtype = 2'b10;
            default: bus.brtype = 2'b00;
          endcase
        end
        JUMP: begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = 2'b01;
        end
        JR: begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = 2'b10;
        end
        SYSCALL: begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = 2'b11;
        end
        default: begin
          bus.rd = 1'b0;
        end
      endcase
    end
  end

  // An instruction retires on the edge that leaves its final state; a store
  // only leaves MEMWR once the write is accepted.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      ALUWB_R, ALUWB_I, MEMWB, BRANCH, JUMP, JR, SYSCALL: retire = 1'b1;
      MEMWR:   retire = bus.mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_q <= 32'd0;
    end else if (retire) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] exp_count;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction kinds for the reference model
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                 K_J = 5, K_JR = 6, K_SYS = 7, K_BAD = 8;

  logic [5:0] i_ops   [5] = '{6'b001111, 6'b001000, 6'b001100, 6'b001101, 6'b001110};
  logic [5:0] br_ops  [3] = '{6'b000001, 6'b000010, 6'b000101};
  logic [5:0] bad_ops [4] = '{6'b000011, 6'b111111, 6'b100000, 6'b001001};

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs_ctrl();
    return {bus.irwrite, bus.pcwrite, bus.pcwritecond, bus.iord, bus.rd, bus.we,
            bus.regwrite, bus.alusrc, bus.illegal,
            bus.regdst, bus.reginsrc, bus.brtype, bus.pcsrc};
  endfunction

  // Expected control word from the per-state output table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic mr, input logic bad);
    logic irw, pcw, pcc, iord, rdv, wev, rw, als, ill;
    logic [1:0] rdst, rin, brt, pcs;
    {irw, pcw, pcc, iord, rdv, wev, rw, als, ill} = '0;
    {rdst, rin, brt, pcs} = '0;
    case (st)
      0:  begin rdv = 1; irw = mr; pcw = mr; end
      1:  ill = bad;
      3:  als = 1;
      4:  begin rw = 1; rdst = 2'b01; rin = 2'b01; end
      5:  begin rw = 1; rin = 2'b01; als = 1; end
      6:  als = 1;
      7:  begin rdv = 1; iord = 1; als = 1; end
      8:  rw = 1;
      9:  begin wev = 1; iord = 1; als = 1; end
      10: begin
            pcc = 1;
            brt = (op == 6'b000001) ? 2'b11 : (op == 6'b000010) ? 2'b01 : 2'b10;
          end
      11: begin pcw = 1; pcs = 2'b01; end
      12: begin pcw = 1; pcs = 2'b10; end
      13: begin pcw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {irw, pcw, pcc, iord, rdv, wev, rw, als, ill, rdst, rin, brt, pcs};
  endfunction

  // Runs one instruction: sf FETCH stall cycles, sm stall cycles in MEMRD/MEMWR.
  // abort >= 0 asserts reset right after checking that cycle index.
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] f,
                           input int sf, input int sm, input int abort);
    int   st_q[$];
    logic mr_q[$];
    logic bad;
    bad = (kind == K_BAD);
    for (int k = 0; k < sf; k++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (kind)
      K_R: begin st_q.push_back(2); mr_q.push_back(1'($urandom));
                 st_q.push_back(4); mr_q.push_back(1'($urandom)); end
      K_I: begin st_q.push_back(3); mr_q.push_back(1'($urandom));
                 st_q.push_back(5); mr_q.push_back(1'($urandom)); end
      K_LW: begin
        st_q.push_back(6); mr_q.push_back(1'($urandom));
        for (int k = 0; k < sm; k++) begin st_q.push_back(7); mr_q.push_back(1'b0); end
        st_q.push_back(7); mr_q.push_back(1'b1);
        st_q.push_back(8); mr_q.push_back(1'($urandom));
      end
      K_SW: begin
        st_q.push_back(6); mr_q.push_back(1'($urandom));
        for (int k = 0; k < sm; k++) begin st_q.push_back(9); mr_q.push_back(1'b0); end
        st_q.push_back(9); mr_q.push_back(1'b1);
      end
      K_BR:  begin st_q.push_back(10); mr_q.push_back(1'($urandom)); end
      K_J:   begin st_q.push_back(11); mr_q.push_back(1'($urandom)); end
      K_JR:  begin st_q.push_back(12); mr_q.push_back(1'($urandom)); end
      K_SYS: begin st_q.push_back(13); mr_q.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.opcode = op;
        bus.fn     = f;
      end
      bus.mem_ready = mr_q[i];
      #1;
      chk("state", i, 32'(bus.state), 32'(st_q[i]));
      chk("ctrl", i, 32'(obs_ctrl()), 32'(exp_ctrl(st_q[i], op, mr_q[i], bad)));
      if (i == 0) chk("count", i, bus.instr_count, exp_count);
      if (i == abort) begin
        rst = 1'b1;
        #1;
        chk("rst_state", i, 32'(bus.state), 32'd0);
        chk("rst_we", i, 32'(bus.we), 32'd0);
        chk("rst_ctrl", i, 32'(obs_ctrl()), 32'd0);
        chk("rst_count", i, bus.instr_count, 32'd0);
        exp_count = 32'd0;
        @(negedge clk);
        #1;
        chk("rst_hold_ctrl", i, 32'(obs_ctrl()), 32'd0);
        chk("rst_hold_state", i, 32'(bus.state), 32'd0);
        rst = 1'b0;
        return;
      end
    end
    if (kind != K_BAD) exp_count = exp_count + 32'd1;
  endtask

  task automatic pick(input int kind, output logic [5:0] op, output logic [5:0] f);
    f = 6'($urandom);
    case (kind)
      K_R:   begin op = 6'b000000; f = $urandom_range(0, 1) ? 6'b100000 : 6'b100010; end
      K_I:   op = i_ops[$urandom_range(0, 4)];
      K_LW:  op = 6'b100011;
      K_SW:  op = 6'b101011;
      K_BR:  op = br_ops[$urandom_range(0, 2)];
      K_J:   op = 6'b000100;
      K_JR:  begin op = 6'b000000; f = 6'b001000; end
      K_SYS: begin op = 6'b000000; f = 6'b001100; end
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          op = 6'b000000;
          f  = $urandom_range(0, 1) ? 6'b111111 : 6'b100001;
        end else begin
          op = bad_ops[$urandom_range(0, 3)];
        end
      end
    endcase
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] f;
    int kind;
    checks        = 0;
    failures      = 0;
    exp_count     = 32'd0;
    rst           = 1'b1;
    bus.opcode    = 6'd0;
    bus.fn        = 6'd0;
    bus.mem_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 0, 32'(bus.state), 32'd0);
    chk("reset_ctrl", 0, 32'(obs_ctrl()), 32'd0);
    chk("reset_count", 0, bus.instr_count, 32'd0);
    rst = 1'b0;

    // Directed instructions
    run_instr(K_R,   6'b000000, 6'b100000, 0, 0, -1);  // add
    run_instr(K_LW,  6'b100011, 6'b000000, 0, 2, -1);  // lw, 2 stall cycles in MEMRD
    run_instr(K_BR,  6'b000101, 6'b000000, 0, 0, -1);  // bne
    run_instr(K_J,   6'b000100, 6'b000000, 1, 0, -1);  // j with one fetch stall
    run_instr(K_JR,  6'b000000, 6'b001000, 0, 0, -1);  // jr
    run_instr(K_SYS, 6'b000000, 6'b001100, 0, 0, -1);  // syscall
    run_instr(K_BAD, 6'b000000, 6'b111111, 0, 0, -1);  // illegal R-type fn
    run_instr(K_SW,  6'b101011, 6'b000000, 0, 1, -1);  // sw, 1 stall cycle

    // Reset in the middle of a stalled store (index 3 = first MEMWR cycle)
    run_instr(K_SW,  6'b101011, 6'b000000, 0, 3, 3);
    run_instr(K_I,   6'b001000, 6'b000000, 0, 0, -1);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 8);
      pick(kind, op, f);
      run_instr(kind, op, f, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    // Counter wrap: preload all-ones while idling in FETCH, then retire one addi
    @(negedge clk);
    bus.mem_ready = 1'b0;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr(K_I, 6'b001000, 6'b000000, 0, 0, -1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("wrap_count", 0, bus.instr_count, 32'd0);
    chk("wrap_model", 0, bus.instr_count, exp_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
